// File: rtl/config_pkg.sv
// config_pkg: shared widths, idle/terminator address and loader state for the config bus.
package config_pkg;
  localparam int CFG_ADDR_W = 32;
  localparam int CFG_DATA_W = 32;
  localparam int CFG_RECORD_BYTES = 8;
  localparam logic [CFG_ADDR_W-1:0] CFG_IDLE_ADDR = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {COLLECT, DRIVE, DONE} loader_state_e;
endpackage

// File: rtl/config_stream_loader_if.sv
// config_stream_loader_if: host byte stream plus the broadcast config bus and status.
interface config_stream_loader_if;
  import config_pkg::*;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [CFG_ADDR_W-1:0] config_addr;
  logic [CFG_DATA_W-1:0] config_data;
  logic                  done;
  logic [15:0]           records_loaded;
  modport master (output in_data, in_valid, input in_ready, config_addr, config_data, done, records_loaded);
  modport slave (input in_data, in_valid, output in_ready, config_addr, config_data, done, records_loaded);
endinterface

// File: rtl/config_record_assembler.sv
// config_record_assembler: shifts bytes MSB-first into an 8-byte record and strobes on the last byte.
module config_record_assembler
  import config_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  record_valid_o,
  output logic [CFG_ADDR_W-1:0] addr_o,
  output logic [CFG_DATA_W-1:0] data_o
);
  localparam int REC_W = CFG_RECORD_BYTES * 8;
  logic [REC_W-1:0] shift_q, shift_d;
  logic [2:0]       idx_q;
  // The strobe sees the incoming byte so the top can latch the record on the same edge.
  assign shift_d = {shift_q[REC_W-9:0], byte_i};
  assign record_valid_o = byte_valid_i && idx_q == 3'(CFG_RECORD_BYTES - 1);
  assign addr_o = shift_d[REC_W-1 -: CFG_ADDR_W];
  assign data_o = shift_d[CFG_DATA_W-1:0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= shift_d;
      idx_q   <= idx_q + 3'd1;
    end
  end
endmodule

// File: rtl/config_stream_loader.sv
// config_stream_loader: assembles address/data records from a byte stream and holds each on the config bus.
module config_stream_loader
  import config_pkg::*;
#(
  parameter int                    HOLD_CYCLES = 2,
  parameter logic [CFG_ADDR_W-1:0] IDLE_ADDR   = CFG_IDLE_ADDR
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  config_stream_loader_if.slave bus
);
  loader_state_e         state_q;
  logic [7:0]            hold_q;
  logic [CFG_ADDR_W-1:0] addr_q, rec_addr;
  logic [CFG_DATA_W-1:0] data_q, rec_data;
  logic [15:0]           count_q;
  logic                  done_q, rec_valid, accept;
  assign bus.in_ready = state_q == COLLECT && !restart;
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.config_addr = addr_q;
  assign bus.config_data = data_q;
  assign bus.done = done_q;
  assign bus.records_loaded = count_q;
  config_record_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (restart),
    .byte_valid_i  (accept),
    .byte_i        (bus.in_data),
    .record_valid_o(rec_valid),
    .addr_o        (rec_addr),
    .data_o        (rec_data)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      hold_q  <= '0;
      addr_q  <= IDLE_ADDR;
      data_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else if (restart) begin
      state_q <= COLLECT;
      hold_q  <= '0;
      addr_q  <= IDLE_ADDR;
      data_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: if (rec_valid) begin
          if (rec_addr == IDLE_ADDR) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRIVE;
            addr_q  <= rec_addr;
            data_q  <= rec_data;
            hold_q  <= '0;
            count_q <= count_q == 16'hFFFF ? count_q : count_q + 16'd1;
          end
        end
        DRIVE: begin
          hold_q <= hold_q + 8'd1;
          if (hold_q == 8'(HOLD_CYCLES - 1)) begin
            state_q <= COLLECT;
            addr_q  <= IDLE_ADDR;
            data_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/config_stream_loader.md
# config_stream_loader

Configuration loader that sits at the array edge and drives the shared `config_addr` / `config_data` bus that every tile's address matchers decode. It accepts a byte stream from the host over a valid/ready handshake and assembles 8-byte records: a 32-bit address followed by 32-bit data. It presents each record on the bus for a fixed number of cycles, then parks the bus on an idle address that no tile matches. A terminator record ends the load and raises `done`.

## Interface
Parameters:
- `HOLD_CYCLES`, 2, cycles each record stays on the bus; legal range 1..255.
- `IDLE_ADDR`, 32'hFFFF_FFFF, address driven when no record is active; also the terminator address.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `restart`  in  1  synchronous pulse; aborts the current load and returns to collecting.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `config_addr`  out  32  configuration address broadcast to tiles (registered).
- `config_data`  out  32  configuration data broadcast to tiles (registered).
- `done`  out  1  terminator received; sticky.
- `records_loaded`  out  16  non-terminator records issued; saturates at 16'hFFFF.

## Operation
- States: COLLECT, DRIVE, DONE.
- **Reset values:**
  - state COLLECT; byte index 0; shift register 0.
  - `config_addr` = `IDLE_ADDR`, `config_data` = 0.
  - `done` = 0, `records_loaded` = 0.
- `in_ready` = (state == COLLECT) && !`restart`, computed combinationally.
- **COLLECT:**
  - A byte is accepted when `in_valid && in_ready`.
  - Bytes shift into a 64-bit register, MSB first: bytes 0..3 form the address, bytes 4..7 form the data, both big-endian.
  - The byte index counts 0..7.
- **On acceptance of byte 7:**
  - If the assembled address equals `IDLE_ADDR`: go to DONE and set `done`. The bus stays idle and `records_loaded` is unchanged.
  - Otherwise: load `config_addr` / `config_data` with the record, increment `records_loaded` (saturating), clear the hold counter, go to DRIVE.
  - The byte index wraps to 0 in both cases.
- **DRIVE:**
  - `in_ready` = 0; the hold counter increments every cycle.
  - On the cycle the counter reaches `HOLD_CYCLES`-1: `config_addr` returns to `IDLE_ADDR`, `config_data` returns to 0, state goes to COLLECT.
- **DONE:**
  - `in_ready` = 0; the bus is idle; `done` stays 1.
  - Only `restart` or `reset` leaves this state.
- **`restart` (any state):**
  - Next edge: state COLLECT, byte index 0, `done` 0, `records_loaded` 0, bus idle.
  - A byte presented in the same cycle is not accepted, because `in_ready` is low.
  - In DRIVE, the record is cut short; the bus is idle from the next edge.
- A partial record (index 1..7) is kept indefinitely while `in_valid` is low. There is no timeout.

## Timing
- Record latency: byte 7 accepted at edge N → bus shows the record from edge N through edge N+`HOLD_CYCLES`. The bus is idle from edge N+`HOLD_CYCLES`.
- `in_ready` is low from edge N until edge N+`HOLD_CYCLES`. The first byte of the next record can be accepted at edge N+`HOLD_CYCLES`+1.
- Peak throughput: one record per 8+`HOLD_CYCLES` cycles.
- `done` rises at the edge that accepts the terminator's byte 7.
- `reset` acts immediately and asynchronously on every register. Release is assumed synchronised upstream.

## Structure
- Shared package `config_pkg` holds:
  - `CFG_ADDR_W` = 32, `CFG_DATA_W` = 32;
  - `CFG_RECORD_BYTES` = 8;
  - the default idle/terminator address constant;
  - the loader state enum (COLLECT/DRIVE/DONE).
- The tile-side address matchers also import this package, so both ends use the same idle address.
- One sub-module, `config_record_assembler`, contains:
  - the byte shifter and 0..7 index;
  - a one-cycle `record_valid` strobe, with address and data outputs;
  - an index clear input driven by `restart`.
- The top level holds the FSM, hold counter, output registers and record counter.

## Test plan
- **Single record:** stream 00 00 00 11, DE AD BE EF with `HOLD_CYCLES`=2 → `config_addr`=32'h0000_0011 and `config_data`=32'hDEAD_BEEF for exactly 2 cycles. Then the bus shows `IDLE_ADDR`/0 and `records_loaded`=1.
- **Back-to-back with gaps:** 3 records, `in_valid` toggled randomly → each record appears in order. `in_ready` is never high during DRIVE. `records_loaded`=3.
- **Terminator:** FF FF FF FF 00 00 00 00 after one record → `done`=1, `in_ready`=0, bus idle, `records_loaded`=1. Further `in_valid` is ignored.
- **Restart mid-DRIVE:** pulse `restart` on the first DRIVE cycle while `in_valid`=1 → bus idle at the next edge, count 0, no byte accepted that cycle, next record assembles from byte 0.
- **Partial record + restart:** 5 bytes, then `restart`, then a full record A → only A appears on the bus.
- **Async reset mid-record:** assert `reset`=0 between edges during DRIVE → outputs are reset values immediately, before the next clock edge.
